// File: rtl/board_io_ctrl.sv
// Avalon-MM button/LED controller: debounced buttons with press capture and IRQ, plus LED drive (static/blink/PWM).
// Latency: reads return 1 cycle after chipselect&read; writes act on the sampling edge; led is registered (+1 cycle).
// Backpressure: none; the slave accepts every access with no wait states.
//
// Ports: clk/reset_n (async active-low); Avalon slave address/chipselect/read/write/writedata/readdata;
//        irq (level, active-high); button_n (raw, async, 0 = pressed); led (1 = on).
// Option: define BOARD_IO_CTRL_PWM_EN to build the PWM counter, the PWM_DUTY register and LED mode 2.
module board_io_ctrl #(
  parameter int BTN_W           = 4,
  parameter int LED_W           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_W         = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [BTN_W-1:0]  button_n,
  output logic [LED_W-1:0]  led
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                 wr_en, rd_en;
  logic [BTN_W-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [BTN_W-1:0]     stable_q, stable_d, edge_q, edge_d, mask_q, mask_d;
  logic [BTN_W-1:0]     press, w1c;
  logic [CNT_W-1:0]     cnt_q [BTN_W];
  logic [CNT_W-1:0]     cnt_d [BTN_W];
  logic [LED_W-1:0]     led_out_q, led_out_d, led_q, led_d;
  logic [2*LED_W-1:0]   led_mode_q, led_mode_d;
  logic [BLINK_W-1:0]   period_q, period_d, presc_q, presc_d;
  logic                 period_wr;
  logic                 phase_q, phase_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 unused_wdata;
`ifdef BOARD_IO_CTRL_PWM_EN
  logic [7:0]           pwm_cnt_q, pwm_cnt_d, duty_q, duty_d;
  logic                 pwm_on;
`endif

  assign wr_en        = chipselect & write;
  assign rd_en        = chipselect & read;
  assign unused_wdata = ^writedata;

  // Debounce: inputs are inverted before the synchroniser so the reset value 0 means released.
  always_comb begin
    sync1_d  = ~button_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < BTN_W; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
          press[i]    = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Register writes, edge capture and blink prescaler.
  always_comb begin
    mask_d     = mask_q;
    led_out_d  = led_out_q;
    led_mode_d = led_mode_q;
    period_d   = period_q;
    period_wr  = 1'b0;
    w1c        = '0;
`ifdef BOARD_IO_CTRL_PWM_EN
    duty_d     = duty_q;
    pwm_cnt_d  = pwm_cnt_q + 8'd1;
`endif
    if (wr_en) begin
      case (address)
        3'd1: w1c        = writedata[BTN_W-1:0];
        3'd2: mask_d     = writedata[BTN_W-1:0];
        3'd3: led_out_d  = writedata[LED_W-1:0];
        3'd4: led_mode_d = writedata[2*LED_W-1:0];
        3'd5: begin
          period_d  = writedata[BLINK_W-1:0];
          period_wr = 1'b1;
        end
`ifdef BOARD_IO_CTRL_PWM_EN
        3'd6: duty_d     = writedata[7:0];
`endif
        default: ;
      endcase
    end
    // A press accepted on the same edge as a W1C clear survives.
    edge_d = (edge_q & ~w1c) | press;

    presc_d = presc_q + BLINK_W'(1);
    phase_d = phase_q;
    if (period_wr || period_q == '0) begin
      presc_d = '0;
      phase_d = 1'b0;
    end else if (presc_q == period_q) begin
      presc_d = '0;
      phase_d = ~phase_q;
    end
  end

`ifdef BOARD_IO_CTRL_PWM_EN
  assign pwm_on = pwm_cnt_q < duty_q;
`endif

  // LED drive from the current register/phase values; mode 3 (and 2 without PWM) is static.
  always_comb begin
    for (int i = 0; i < LED_W; i++) begin
      case (led_mode_q[2*i +: 2])
        2'd1:    led_d[i] = led_out_q[i] & phase_q;
`ifdef BOARD_IO_CTRL_PWM_EN
        2'd2:    led_d[i] = led_out_q[i] & pwm_on;
`endif
        default: led_d[i] = led_out_q[i];
      endcase
    end
  end

  // readdata holds between reads.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      case (address)
        3'd0:    rdata_d = 32'(stable_q);
        3'd1:    rdata_d = 32'(edge_q);
        3'd2:    rdata_d = 32'(mask_q);
        3'd3:    rdata_d = 32'(led_out_q);
        3'd4:    rdata_d = 32'(led_mode_q);
        3'd5:    rdata_d = 32'(period_q);
`ifdef BOARD_IO_CTRL_PWM_EN
        3'd6:    rdata_d = 32'(duty_q);
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      led_out_q  <= '0;
      led_mode_q <= '0;
      period_q   <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
      led_q      <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= '0;
`ifdef BOARD_IO_CTRL_PWM_EN
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      led_out_q  <= led_out_d;
      led_mode_q <= led_mode_d;
      period_q   <= period_d;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < BTN_W; i++) cnt_q[i] <= cnt_d[i];
`ifdef BOARD_IO_CTRL_PWM_EN
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
`endif
    end
  end

  assign irq      = |(edge_q & mask_q);
  assign led      = led_q;
  assign readdata = rdata_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl: register access, debounce, edge capture/IRQ, LED modes and async reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every access completes in fixed cycles, so no open-ended waits exist.
module tb_board_io_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  button_n;
  logic [1:0]  led;

  int checks = 0;
  int errors = 0;

  board_io_ctrl #(
    .BTN_W(4), .LED_W(2), .DEBOUNCE_CYCLES(16), .BLINK_W(24)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .irq(irq), .button_n(button_n), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  initial begin
    logic [31:0] d;
    int          hi;

    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; button_n = 4'b1111;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_led", {30'b0, led}, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Register boundaries: RO ignores writes, unused bits read 0, reserved reads 0.
    wr(3'd0, 32'hF);
    rd(3'd0, d); check("ro_btn_state", d, 32'h0);
    wr(3'd2, 32'hFFFF_FFFF);
    rd(3'd2, d); check("mask_width", d, 32'hF);
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, d); check("period_width", d, 32'h00FF_FFFF);
    wr(3'd5, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, d); check("reserved_rd", d, 32'h0);

    // Glitch of 10 cycles on button 1 is rejected.
    @(negedge clk); button_n = 4'b1101;
    repeat (10) @(negedge clk);
    button_n = 4'b1111;
    repeat (30) @(negedge clk);
    rd(3'd0, d); check("glitch_state", d, 32'h0);
    rd(3'd1, d); check("glitch_edge", d, 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Steady press of button 0: accepted on edge 18 after the change.
    @(negedge clk); button_n = 4'b1110;
    repeat (17) @(posedge clk);
    @(negedge clk); check("accept_irq_e17", {31'b0, irq}, 32'h0);
    @(negedge clk); check("accept_irq_e18", {31'b0, irq}, 32'h1);
    rd(3'd0, d); check("accept_state", d, 32'h1);
    rd(3'd1, d); check("accept_edge", d, 32'h1);

    // Release sets nothing; then W1C collides with a new accepted press.
    @(negedge clk); button_n = 4'b1111;
    repeat (30) @(negedge clk);
    rd(3'd0, d); check("release_state", d, 32'h0);
    check("release_irq", {31'b0, irq}, 32'h1);
    @(negedge clk); button_n = 4'b1110;
    repeat (17) @(posedge clk);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    rd(3'd1, d); check("race_edge", d, 32'h1);
    rd(3'd0, d); check("race_state", d, 32'h1);
    check("race_irq", {31'b0, irq}, 32'h1);
    wr(3'd1, 32'h1);
    rd(3'd1, d); check("w1c_edge", d, 32'h0);
    check("w1c_irq", {31'b0, irq}, 32'h0);

    // Blink: LED0 static, LED1 blinking with half-period 5.
    wr(3'd3, 32'h3);
    wr(3'd4, 32'h4);
    rd(3'd4, d); check("led_mode_rd", d, 32'h4);
    wr(3'd5, 32'h4);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      check($sformatf("blink_k%0d", k), {30'b0, led}, {30'b0, 1'(((k - 1) / 5) % 2), 1'b1});
    end
    wr(3'd5, 32'h0);
    repeat (3) @(negedge clk);
    check("blink_stop", {30'b0, led}, 32'h1);

`ifdef BOARD_IO_CTRL_PWM_EN
    wr(3'd6, 32'd64);
    rd(3'd6, d); check("pwm_duty_rd", d, 32'd64);
    wr(3'd4, 32'h2);
    wr(3'd3, 32'h1);
    repeat (3) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      if (led[0]) hi++;
    end
    check("pwm_high_cycles", 32'(hi), 32'd64);
`else
    wr(3'd6, 32'd64);
    rd(3'd6, d); check("pwm_off_rd", d, 32'h0);
    wr(3'd4, 32'h2);
    wr(3'd3, 32'h1);
    repeat (3) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (led == 2'b01) hi++;
    end
    check("pwm_off_static", 32'(hi), 32'd300);
`endif

    // Mid-operation reset while blinking with irq high.
    wr(3'd3, 32'h3);
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h4);
    @(negedge clk); button_n = 4'b1011;
    repeat (25) @(negedge clk);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    rd(3'd0, d); check("pre_rst_state", d, 32'h4);
    check("pre_rst_led0", {31'b0, led[0]}, 32'h1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("midrst_led", {30'b0, led}, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    check("midrst_readdata", readdata, 32'h0);
    button_n = 4'b1111;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      check($sformatf("post_rst_reg%0d", a), d, 32'h0);
    end
    check("post_rst_led", {30'b0, led}, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
